hls_pipe_arbiter: RTL

//  Shares one fixed-latency, fully pipelined HLS operator (e.g. the fpadd_sub

---
 rtl/hls_pipe_arbiter_if.sv | 27 ++
 rtl/hls_pipe_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/hls_pipe_arbiter_if.sv
// Handshake bundle between HLS requester FSMs, the round-robin arbiter and the
// shared fixed-latency operator.
interface hls_pipe_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] p0_flat;
   logic [NREQ*WIDTH-1:0] p1_flat;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      out;
   logic                  busy;
   logic [WIDTH-1:0]      unit_p0;
   logic [WIDTH-1:0]      unit_p1;
   logic [WIDTH-1:0]      unit_out;

   modport master (
      output req, p0_flat, p1_flat, unit_out,
      input  grant, ack, out, busy, unit_p0, unit_p1
   );

   modport slave (
      input  req, p0_flat, p1_flat, unit_out,
      output grant, ack, out, busy, unit_p0, unit_p1
   );
endinterface

// File: rtl/hls_pipe_arbiter.sv
// Round-robin sharing of one fully pipelined operator between NREQ requesters;
// a tag pipeline matching the operator latency routes each result back.
module hls_pipe_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   hls_pipe_arbiter_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     sel_idx;
   logic               issue;
   logic [NREQ-1:0]    grant_vec;
   logic [LATENCY-1:0] vld_q;
   logic [IDW-1:0]     id_q [LATENCY];
   logic [NREQ-1:0]    ack_q, ack_d;
   logic [WIDTH-1:0]   out_q;
   logic               busy_q;

   function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      sel_idx   = ptr_q;
      issue     = 1'b0;
      grant_vec = '0;
      ptr_d     = ptr_q;
      ack_d     = '0;
      // Scan from the farthest offset down so the first requester after ptr wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rst && bus.req[wrap_idx(int'(ptr_q), k)]) begin
            sel_idx = wrap_idx(int'(ptr_q), k);
            issue   = 1'b1;
         end
      end
      if (issue) begin
         grant_vec[sel_idx] = 1'b1;
         ptr_d = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + IDW'(1);
      end
      if (vld_q[LATENCY-1]) ack_d[id_q[LATENCY-1]] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q  <= '0;
         vld_q  <= '0;
         ack_q  <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         vld_q  <= (vld_q << 1) | LATENCY'(issue);
         ack_q  <= ack_d;
         if (vld_q[LATENCY-1]) out_q <= bus.unit_out;
         // Next-cycle view of the valids plus the ack about to be raised.
         busy_q <= issue | (|vld_q);
      end
   end

   // NOTE: the id pipe carries no reset; an id is only looked at when its valid bit is set.
   always_ff @(posedge clk) begin
      id_q[0] <= sel_idx;
      for (int s = 1; s < LATENCY; s++) id_q[s] <= id_q[s-1];
   end

   assign bus.grant   = grant_vec;
   assign bus.ack     = ack_q;
   assign bus.out     = out_q;
   assign bus.busy    = busy_q;
   assign bus.unit_p0 = bus.p0_flat[int'(sel_idx)*WIDTH +: WIDTH];
   assign bus.unit_p1 = bus.p1_flat[int'(sel_idx)*WIDTH +: WIDTH];
endmodule
